// File: rtl/ntt_pkg.sv
// Shared NTT datapath constants: default operand width and modulus, derived
// Barrett factors and the residue width.
package ntt_pkg;

  localparam int unsigned N_DEF = 17;
  localparam int unsigned Q_DEF = 12289;
  localparam int unsigned K_DEF = 2 * N_DEF;
  localparam int unsigned RES_W = N_DEF;

  // Barrett factor floor(2^k / q)
  function automatic longint unsigned barrett_m(input int unsigned k, input int unsigned q);
    return (64'd1 << k) / 64'(q);
  endfunction

  localparam longint unsigned M_DEF = barrett_m(K_DEF, Q_DEF);

endpackage

// File: rtl/mod_correct.sv
// Final +/-Q correction of a value in [-Q, 2Q) into [0, Q); with
// BARRETT_CENTERED_EN defined the result is centered to [-(Q-1)/2, (Q-1)/2].
module mod_correct
  import ntt_pkg::*;
#(
  parameter int unsigned W = N_DEF,
  parameter int unsigned Q = Q_DEF
) (
  input  logic signed [W:0]   r,
  output logic signed [W-1:0] res_c
);

  localparam int unsigned R_W = W + 1;
  localparam logic signed [W:0] Q_S = R_W'(Q);
`ifdef BARRETT_CENTERED_EN
  localparam logic signed [W:0] HALF = R_W'((Q - 1) / 2);
`endif

  logic signed [W:0] c;

  always_comb begin
    c = r;
    if (r[W]) begin
      c = r + Q_S;
    end else if (r >= Q_S) begin
      c = r - Q_S;
    end
`ifdef BARRETT_CENTERED_EN
    if (c > HALF) begin
      c = c - Q_S;
    end
`endif
    res_c = W'(c);
  end

endmodule

// File: rtl/barrett_reducer.sv
// Pipelined signed Barrett reduction of 2N-bit products mod Q with a
// valid/ready stream; BARRETT_CENTERED_EN adds a stage and centers residues.
module barrett_reducer
  import ntt_pkg::*;
#(
  parameter int unsigned N = N_DEF,
  parameter int unsigned Q = Q_DEF
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [2*N-1:0] in_data,
  input  logic           in_last,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [N-1:0]   out_data,
  output logic           out_last
);

  localparam int unsigned     K    = 2 * N;
  localparam int unsigned     X_W  = 2 * N;
  // reuse the package constant for the default build
  localparam longint unsigned M    = (N == RES_W && Q == Q_DEF) ? M_DEF : barrett_m(K, Q);
  localparam int unsigned     M_W  = $clog2(M + 1) + 1;
  localparam int unsigned     T_W  = X_W + M_W;
  localparam int unsigned     QQ_W = X_W + 2;
  localparam int unsigned     R_W  = N + 1;

  localparam logic signed [M_W-1:0]  M_S = M_W'(M);
  localparam logic signed [QQ_W-1:0] Q_S = QQ_W'(Q);

  logic                   en;
  logic                   v1, v2, l1, l2;
  logic signed [X_W-1:0]  x1, x2;
  logic signed [QQ_W-1:0] qq2;
  logic signed [T_W-1:0]  t_c;
  logic signed [M_W-1:0]  q_c;
  logic signed [QQ_W-1:0] qq_c, d_c;
  logic signed [R_W-1:0]  r_c, corr_in;
  logic signed [N-1:0]    res_c;
  logic                   pre_v, pre_l;

  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  // quotient estimate floor(x*M / 2^K), then r = x - q*Q in [-Q, 2Q)
  assign t_c  = T_W'(x1) * T_W'(M_S);
  assign q_c  = M_W'(t_c >>> K);
  assign qq_c = QQ_W'(q_c) * Q_S;
  assign d_c  = QQ_W'(x2) - qq2;
  assign r_c  = R_W'(d_c);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1        <= 1'b0;
      l1        <= 1'b0;
      x1        <= '0;
      v2        <= 1'b0;
      l2        <= 1'b0;
      x2        <= '0;
      qq2       <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
    end else if (en) begin
      v1        <= in_valid;
      l1        <= in_valid & in_last;
      x1        <= in_data;
      v2        <= v1;
      l2        <= l1;
      x2        <= x1;
      qq2       <= qq_c;
      out_valid <= pre_v;
      out_last  <= pre_l;
      out_data  <= res_c;
    end
  end

`ifdef BARRETT_CENTERED_EN
  logic                  v3, l3;
  logic signed [R_W-1:0] r3;

  // extra register stage ahead of correction and centering
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v3 <= 1'b0;
      l3 <= 1'b0;
      r3 <= '0;
    end else if (en) begin
      v3 <= v2;
      l3 <= l2;
      r3 <= r_c;
    end
  end

  assign corr_in = r3;
  assign pre_v   = v3;
  assign pre_l   = l3;
`else
  assign corr_in = r_c;
  assign pre_v   = v2;
  assign pre_l   = l2;
`endif

  mod_correct #(
    .W(N),
    .Q(Q)
  ) u_mod_correct (
    .r    (corr_in),
    .res_c(res_c)
  );

endmodule
